// File: rtl/timer_pkg.sv
// Shared constants for the MM:SS.cc countdown timer: state encoding, digit
// moduli, BCD field offsets and a preset validity helper.
package timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int NUM_DIGITS = 6;

  localparam int MOD_C1  = 10;
  localparam int MOD_C10 = 10;
  localparam int MOD_S1  = 10;
  localparam int MOD_S10 = 6;
  localparam int MOD_M1  = 10;
  localparam int MOD_M10 = 10;

  localparam int OFF_C1  = 0;
  localparam int OFF_C10 = 4;
  localparam int OFF_S1  = 8;
  localparam int OFF_S10 = 12;
  localparam int OFF_M1  = 16;
  localparam int OFF_M10 = 20;

  // Digit index 0 is C1 (least significant), index 5 is M10.
  function automatic int digit_mod(input int idx);
    case (idx)
      0:       return MOD_C1;
      1:       return MOD_C10;
      2:       return MOD_S1;
      3:       return MOD_S10;
      4:       return MOD_M1;
      default: return MOD_M10;
    endcase
  endfunction

  function automatic logic bcd_valid(input logic [23:0] v);
    logic ok;
    ok = (v[OFF_C1  +: 4] <= 4'd9) && (v[OFF_C10 +: 4] <= 4'd9) &&
         (v[OFF_S1  +: 4] <= 4'd9) && (v[OFF_S10 +: 4] <= 4'd5) &&
         (v[OFF_M1  +: 4] <= 4'd9) && (v[OFF_M10 +: 4] <= 4'd9);
    return ok;
  endfunction

endpackage

// File: rtl/countdown_digit.sv
// One BCD digit of the countdown chain: loadable, decrements with wrap
// to the digit maximum (MOD-1) and raises borrow_out when it wraps so the
// next digit decrements.
module countdown_digit #(
  parameter int MOD = 10
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       dec_en,
  output logic [3:0] q,
  output logic       borrow_out
);

  assign borrow_out = dec_en && (q == 4'd0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q <= 4'd0;
    end else if (load) begin
      q <= load_val;
    end else if (dec_en) begin
      q <= (q == 4'd0) ? 4'(MOD - 1) : q - 4'd1;
    end
  end

endmodule

// File: rtl/countdown_timer.sv
// Presettable MM:SS.cc countdown timer driven by a 100 Hz tick enable.
// Optional build macro COUNTDOWN_AUTO_RELOAD_EN: reload preset on expiry and keep running.
module countdown_timer
  import timer_pkg::*;
#(
  parameter int ALARM_TICKS = 300,
  parameter int ALARM_W     = 9
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        tick_100hz,
  input  logic        btn_start,
  input  logic        btn_clear,
  input  logic        load,
  input  logic [23:0] preset_bcd,
  output logic [23:0] digits_bcd,
  output logic        running,
  output logic        expired,
  output logic        alarm,
  output logic        load_err
);

`ifdef COUNTDOWN_AUTO_RELOAD_EN
  localparam bit AUTO_RELOAD = 1'b1;
`else
  localparam bit AUTO_RELOAD = 1'b0;
`endif

  localparam logic [ALARM_W-1:0] ALARM_LAST = ALARM_W'(ALARM_TICKS - 1);

  state_t             state;
  logic [23:0]        preset_q;
  logic [ALARM_W-1:0] alarm_cnt;

  logic        digit_load;
  logic [23:0] load_val;
  logic        dec;
  logic [5:0]  dec_chain;
  logic [5:0]  borrow;
  logic        unused_borrow;

  logic count_zero;
  logic count_le1;
  logic load_ok;
  logic reload_now;

  assign count_zero = (digits_bcd == 24'd0);
  // Count is 0 or 1 exactly when every digit above C1 is zero and C1 <= 1.
  assign count_le1  = (digits_bcd[23:1] == 23'd0);
  assign load_ok    = ((state == ST_IDLE) || (state == ST_PAUSE)) && bcd_valid(preset_bcd);
  assign reload_now = AUTO_RELOAD && (preset_q != 24'd0);

  // Digit controls follow the input priority clear > load > start > tick.
  always_comb begin
    digit_load = 1'b0;
    load_val   = preset_q;
    dec        = 1'b0;
    if (btn_clear) begin
      digit_load = 1'b1;
    end else if (load) begin
      if (load_ok) begin
        digit_load = 1'b1;
        load_val   = preset_bcd;
      end
    end else if (btn_start) begin
      if (state == ST_DONE) digit_load = 1'b1;
    end else if (tick_100hz && (state == ST_RUN)) begin
      if (count_le1) begin
        digit_load = 1'b1;
        load_val   = reload_now ? preset_q : 24'd0;
      end else begin
        dec = 1'b1;
      end
    end
  end

  assign dec_chain     = {borrow[4:0], dec};
  assign unused_borrow = borrow[5];

  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
    countdown_digit #(.MOD(digit_mod(i))) u_digit (
      .clk        (clk),
      .reset_n    (reset_n),
      .load       (digit_load),
      .load_val   (load_val[4*i +: 4]),
      .dec_en     (dec_chain[i]),
      .q          (digits_bcd[4*i +: 4]),
      .borrow_out (borrow[i])
    );
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      preset_q  <= 24'd0;
      alarm_cnt <= '0;
      running   <= 1'b0;
      expired   <= 1'b0;
      alarm     <= 1'b0;
      load_err  <= 1'b0;
    end else begin
      expired  <= 1'b0;
      load_err <= 1'b0;
      if (btn_clear) begin
        state     <= ST_IDLE;
        running   <= 1'b0;
        alarm     <= 1'b0;
        alarm_cnt <= '0;
      end else if (load) begin
        if (load_ok) preset_q <= preset_bcd;
        else         load_err <= 1'b1;
      end else if (btn_start) begin
        case (state)
          ST_IDLE: begin
            if (!count_zero) begin
              state   <= ST_RUN;
              running <= 1'b1;
            end
          end
          ST_RUN: begin
            state   <= ST_PAUSE;
            running <= 1'b0;
          end
          ST_PAUSE: begin
            state   <= ST_RUN;
            running <= 1'b1;
          end
          default: begin
            state     <= ST_IDLE;
            running   <= 1'b0;
            alarm     <= 1'b0;
            alarm_cnt <= '0;
          end
        endcase
      end else if (tick_100hz) begin
        if ((state == ST_RUN) && count_le1) begin
          expired <= 1'b1;
          if (!reload_now) begin
            state     <= ST_DONE;
            running   <= 1'b0;
            alarm     <= (ALARM_TICKS != 0);
            alarm_cnt <= '0;
          end
        end else if ((state == ST_DONE) && alarm) begin
          alarm_cnt <= alarm_cnt + 1'b1;
          if (alarm_cnt == ALARM_LAST) alarm <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_countdown_timer.sv
// Scoreboard bench for countdown_timer: a centisecond-integer reference model
// predicts each cycle's outputs, a monitor pops and compares them.
module tb_countdown_timer;

  localparam int ALARM_TICKS = 300;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_DONE = 3;

  logic        clk;
  logic        reset_n;
  logic        tick_100hz, btn_start, btn_clear, load;
  logic [23:0] preset_bcd;
  logic [23:0] digits_bcd;
  logic        running, expired, alarm, load_err;

  countdown_timer #(.ALARM_TICKS(ALARM_TICKS), .ALARM_W(9)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .tick_100hz (tick_100hz),
    .btn_start  (btn_start),
    .btn_clear  (btn_clear),
    .load       (load),
    .preset_bcd (preset_bcd),
    .digits_bcd (digits_bcd),
    .running    (running),
    .expired    (expired),
    .alarm      (alarm),
    .load_err   (load_err)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc_n = 0;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  // ---------------- scoreboard ----------------
  typedef struct {
    int          due;
    logic [27:0] val;
  } exp_t;

  exp_t exp_q[$];
  int   n_compared = 0;
  int   n_failed   = 0;

  function automatic logic [27:0] outs();
    return {digits_bcd, running, expired, alarm, load_err};
  endfunction

  always @(negedge clk) begin
    while (exp_q.size() > 0 && exp_q[0].due <= cyc_n) begin
      exp_t e;
      logic [27:0] got;
      e   = exp_q.pop_front();
      got = outs();
      n_compared++;
      if (got !== e.val) begin
        n_failed++;
        if (n_failed <= 30)
          $display("FAIL outputs cycle %0d: got digits=%h run=%b exp=%b alarm=%b lerr=%b, required digits=%h run=%b exp=%b alarm=%b lerr=%b",
                   cyc_n, got[27:4], got[3], got[2], got[1], got[0],
                   e.val[27:4], e.val[3], e.val[2], e.val[1], e.val[0]);
      end
    end
  end

  // ---------------- reference model (integer centiseconds) ----------------
  int m_state, m_count, m_preset, m_alarm_left;
  bit m_exp, m_lerr;

  function automatic int to_cs(input logic [23:0] p);
    return p[23:20] * 60000 + p[19:16] * 6000 + p[15:12] * 1000 +
           p[11:8] * 100 + p[7:4] * 10 + p[3:0];
  endfunction

  function automatic logic [23:0] to_bcd(input int cs);
    int m, s, c;
    c = cs % 100;
    s = (cs / 100) % 60;
    m = cs / 6000;
    return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10), 4'(c / 10), 4'(c % 10)};
  endfunction

  function automatic bit valid_bcd(input logic [23:0] p);
    for (int i = 0; i < 6; i++) begin
      if (p[4*i +: 4] > 4'd9) return 1'b0;
      if (i == 3 && p[4*i +: 4] > 4'd5) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic model_reset();
    m_state = M_IDLE; m_count = 0; m_preset = 0; m_alarm_left = 0;
    m_exp = 0; m_lerr = 0;
  endtask

  task automatic model_step(input bit t, input bit s, input bit c, input bit l,
                            input logic [23:0] p);
    m_exp = 0; m_lerr = 0;
    if (c) begin
      m_state = M_IDLE; m_count = m_preset; m_alarm_left = 0;
    end else if (l) begin
      if ((m_state == M_IDLE || m_state == M_PAUSE) && valid_bcd(p)) begin
        m_preset = to_cs(p); m_count = m_preset;
      end else m_lerr = 1;
    end else if (s) begin
      if (m_state == M_IDLE) begin
        if (m_count != 0) m_state = M_RUN;
      end else if (m_state == M_RUN) m_state = M_PAUSE;
      else if (m_state == M_PAUSE) m_state = M_RUN;
      else begin
        m_state = M_IDLE; m_count = m_preset; m_alarm_left = 0;
      end
    end else if (t) begin
      if (m_state == M_RUN) begin
        if (m_count <= 1) begin
          m_exp = 1;
          if (AUTO && m_preset != 0) m_count = m_preset;
          else begin
            m_count = 0; m_state = M_DONE; m_alarm_left = ALARM_TICKS;
          end
        end else m_count = m_count - 1;
      end else if (m_state == M_DONE && m_alarm_left > 0) begin
        m_alarm_left = m_alarm_left - 1;
      end
    end
  endtask

  // ---------------- driver ----------------
  task automatic cyc(input bit t, input bit s, input bit c, input bit l,
                     input logic [23:0] p);
    exp_t e;
    @(negedge clk);
    tick_100hz = t; btn_start = s; btn_clear = c; load = l; preset_bcd = p;
    model_step(t, s, c, l, p);
    e.due = cyc_n + 1;
    e.val = {to_bcd(m_count), (m_state == M_RUN), m_exp, (m_alarm_left > 0), m_lerr};
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 24'd0);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) cyc(1, 0, 0, 0, 24'd0);
  endtask

  task automatic do_load(input logic [23:0] p);
    cyc(0, 0, 0, 1, p);
  endtask

  task automatic check_reset_outs(input string name);
    n_compared++;
    if (outs() !== 28'd0) begin
      n_failed++;
      $display("FAIL %s: got %h, required 0", name, outs());
    end
  endtask

  task automatic async_reset();
    @(negedge clk);
    tick_100hz = 0; btn_start = 0; btn_clear = 0; load = 0; preset_bcd = 24'd0;
    #2 reset_n = 1'b0;
    #1 check_reset_outs("async_reset");
    @(negedge clk);
    check_reset_outs("reset_hold");
    reset_n = 1'b1;
    model_reset();
  endtask

  function automatic logic [23:0] rand_preset();
    logic [23:0] p;
    int idx;
    if ($urandom_range(0, 3) == 0) p = to_bcd($urandom_range(0, 599999));
    else p = to_bcd($urandom_range(0, 40));
    if ($urandom_range(0, 3) == 0) begin
      idx = $urandom_range(0, 5);
      p[4*idx +: 4] = (idx == 3) ? 4'($urandom_range(6, 15)) : 4'($urandom_range(10, 15));
    end
    return p;
  endfunction

  initial begin
    reset_n = 1'b0;
    tick_100hz = 0; btn_start = 0; btn_clear = 0; load = 0; preset_bcd = 24'd0;
    model_reset();
    #3 check_reset_outs("reset_values");
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;

    // 00:00.05 runs out on the fifth tick, then alarm for 300 ticks
    do_load(24'h000005);
    cyc(1, 1, 0, 0, 24'd0);
    ticks(5);
    ticks(ALARM_TICKS + 4);
    cyc(0, 1, 0, 0, 24'd0);

    // borrow through S10 and C10: 01:00.00 -> 00:59.99
    do_load(24'h010000);
    cyc(0, 1, 0, 0, 24'd0);
    ticks(2);
    cyc(0, 0, 1, 0, 24'd0);

    // pause with coincident tick, resume
    do_load(24'h001000);
    cyc(0, 1, 0, 0, 24'd0);
    cyc(1, 1, 0, 0, 24'd0);
    ticks(2);
    cyc(0, 1, 0, 0, 24'd0);
    ticks(3);

    // invalid and wrong-state loads
    cyc(0, 0, 1, 0, 24'd0);
    do_load(24'h007A00);
    do_load(24'h0A0000);
    do_load(24'h000900);
    cyc(0, 1, 0, 0, 24'd0);
    ticks(2);
    do_load(24'h000100);
    ticks(3);

    // clear and load together while paused: clear wins
    cyc(0, 1, 0, 0, 24'd0);
    cyc(0, 0, 1, 1, 24'h000500);
    idle(2);

    // reset in the middle of a run, preset is gone afterwards
    do_load(24'h001000);
    cyc(0, 1, 0, 0, 24'd0);
    ticks(4);
    async_reset();
    cyc(0, 1, 0, 0, 24'd0);
    cyc(0, 0, 1, 0, 24'd0);
    ticks(2);

    // short preset: continuous with auto reload, otherwise a single expiry
    do_load(24'h000002);
    cyc(0, 1, 0, 0, 24'd0);
    ticks(9);
    cyc(0, 0, 1, 0, 24'd0);

    // randomized traffic
    for (int i = 0; i < 5000; i++) begin
      bit t, s, c, l;
      t = ($urandom_range(0, 2) == 0);
      s = ($urandom_range(0, 24) == 0);
      c = ($urandom_range(0, 79) == 0);
      l = ($urandom_range(0, 29) == 0);
      cyc(t, s, c, l, rand_preset());
    end
    idle(3);
    @(negedge clk);
    @(negedge clk);
    n_compared++;
    if (exp_q.size() != 0) begin
      n_failed++;
      $display("FAIL drain: got %0d pending, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_failed);
    $finish;
  end

endmodule
